draw_dynamic_obst: RTL and testbench

//  Draws the moving obstacle rectangle into the VGA pixel stream. Sits directly

---
 rtl/draw_dynamic_obst.sv | 140 ++++++++++++++
 tb/tb_draw_dynamic_obst.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_dynamic_obst.sv
// Overlays the moving obstacle rectangle on the VGA pixel stream.
// The slow-clock obstacle position is synchronised, filtered for stability,
// and latched once per frame at the rising edge of vblnk so a frame never tears.
module draw_dynamic_obst #(
  parameter int          RECT_WIDTH  = 50,
  parameter int          RECT_HEIGHT = 50,
  parameter logic [11:0] RECT_COLOR  = 12'hF00,
  parameter int          INIT_X      = 600,
  parameter int          INIT_Y      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        obst_px
);

  localparam logic [11:0] INIT_X_V = 12'(INIT_X);
  localparam logic [11:0] INIT_Y_V = 12'(INIT_Y);
  localparam logic [12:0] WIDTH_V  = 13'(RECT_WIDTH);
  localparam logic [12:0] HEIGHT_V = 13'(RECT_HEIGHT);

  // position crossing from the slow clock: two flops, then a one-cycle stability check
  logic [23:0] pos_s1, pos_s2, pos_prev, pos_stable;
  logic        vblnk_d;
  logic [11:0] shadow_x, shadow_y;
  logic        frame_start;

  // S1 registers
  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, hblnk_s1, vsync_s1, vblnk_s1;
  logic [11:0] rgb_s1;
  logic        hit_s1;

  // rectangle bounds widened to 13 bits so large positions never wrap to the left/top
  logic [12:0] x_end, y_end;
  logic        hit;

  // synchroniser plus stability filter: a bus seen mid-change never reaches pos_stable
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_s1     <= '0;
      pos_s2     <= '0;
      pos_prev   <= '0;
      pos_stable <= '0;
    end else begin
      pos_s1   <= {xpos_in, ypos_in};
      pos_s2   <= pos_s1;
      pos_prev <= pos_s2;
      if (pos_s2 == pos_prev) pos_stable <= pos_s2;
    end
  end

  assign frame_start = vblnk_in & ~vblnk_d;

  // per-frame shadow position, updated only as the vertical blanking gap begins
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d  <= 1'b0;
      shadow_x <= INIT_X_V;
      shadow_y <= INIT_Y_V;
    end else begin
      vblnk_d <= vblnk_in;
      if (frame_start) begin
        shadow_x <= pos_stable[23:12];
        shadow_y <= pos_stable[11:0];
      end
    end
  end

  // coverage test against the shadow value held before any same-cycle update
  always_comb begin
    x_end = {1'b0, shadow_x} + WIDTH_V;
    y_end = {1'b0, shadow_y} + HEIGHT_V;
    hit   = ~hblnk_in & ~vblnk_in &
            ({1'b0, hcount_in} >= shadow_x) & ({2'b0, hcount_in} < x_end) &
            ({1'b0, vcount_in} >= shadow_y) & ({2'b0, vcount_in} < y_end);
  end

  // stage 1: register timing, background colour and the hit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      hsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
      hit_s1    <= 1'b0;
    end else begin
      hcount_s1 <= hcount_in;
      vcount_s1 <= vcount_in;
      hsync_s1  <= hsync_in;
      hblnk_s1  <= hblnk_in;
      vsync_s1  <= vsync_in;
      vblnk_s1  <= vblnk_in;
      rgb_s1    <= rgb_in;
      hit_s1    <= hit;
    end
  end

  // stage 2: colour select and output timing
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      obst_px    <= 1'b0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      hblnk_out  <= hblnk_s1;
      vsync_out  <= vsync_s1;
      vblnk_out  <= vblnk_s1;
      rgb_out    <= hit_s1 ? RECT_COLOR : rgb_s1;
      obst_px    <= hit_s1;
    end
  end

endmodule

// File: tb/tb_draw_dynamic_obst.sv
// Bench for draw_dynamic_obst: directed pixels with hand-computed colours,
// expectations queued with the cycle they are due and compared by a monitor.
module tb_draw_dynamic_obst;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos_in, ypos_in;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        obst_px;

  draw_dynamic_obst dut (
    .clk(clk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .obst_px(obst_px)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic [10:0] hc, vc;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
    logic        obst;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: compare whatever is due this cycle
  initial forever begin
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.due != cyc ||
          {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !=
          {e.hc, e.vc, e.hs, e.hb, e.vs, e.vb} ||
          rgb_out != e.rgb || obst_px != e.obst) begin
        errors++;
        $display("FAIL %s: got h=%0d v=%0d hs=%0b hb=%0b vs=%0b vb=%0b rgb=%h obst=%0b, want h=%0d v=%0d hs=%0b hb=%0b vs=%0b vb=%0b rgb=%h obst=%0b",
                 e.name, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
                 rgb_out, obst_px, e.hc, e.vc, e.hs, e.hb, e.vs, e.vb, e.rgb, e.obst);
      end
    end
  end

  // drive one pixel; optionally queue its expected output two cycles later
  task automatic px(input string name, input int h, input int v, input bit hb, input bit vb,
                    input logic [11:0] rgb, input bit chk, input logic [11:0] ergb,
                    input bit eobst);
    exp_t e;
    @(posedge clk);
    #1;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hcount_in[1];
    vsync_in  = vcount_in[0];
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    if (chk) begin
      e.due = cyc + 2; e.name = name;
      e.hc = hcount_in; e.vc = vcount_in; e.hs = hsync_in; e.vs = vsync_in;
      e.hb = hb; e.vb = vb; e.rgb = ergb; e.obst = eobst;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px("idle", 900, 300, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
  endtask

  // one blanking-gap start, then back to visible lines
  task automatic vpulse();
    px("vb", 0, 500, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0);
    idle(2);
  endtask

  // rst asserted for this cycle; everything must read zero after the next edge
  task automatic rst_px(input string name, input int h, input int v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 12'h0AB;
    e.due = cyc + 1; e.name = name;
    e.hc = '0; e.vc = '0; e.hs = 0; e.hb = 0; e.vs = 0; e.vb = 0; e.rgb = '0; e.obst = 0;
    exp_q.push_back(e);
  endtask

  localparam logic [11:0] BG  = 12'h0AB;
  localparam logic [11:0] RED = 12'hF00;

  initial begin
    rst = 1'b1; xpos_in = 12'd0; ypos_in = 12'd0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    idle(2);
    rst_px("reset_zero", 600, 1);
    @(posedge clk); #1; rst = 1'b0;

    // 1: shadow at INIT (600,1) with no frame edge yet
    px("init_hit",      600, 1,  0, 0, BG, 1, RED, 1);
    px("init_left",     599, 1,  0, 0, BG, 1, BG,  0);
    px("init_right_ex", 650, 1,  0, 0, BG, 1, BG,  0);
    px("init_corner",   649, 50, 0, 0, BG, 1, RED, 1);
    px("init_below",    649, 51, 0, 0, BG, 1, BG,  0);
    px("init_hblank",   600, 1,  1, 0, BG, 1, BG,  0);

    // 2: move to (100,200) across a frame boundary
    xpos_in = 12'd100; ypos_in = 12'd200;
    idle(6);
    vpulse();
    px("p2_tl",        100, 200, 0, 0, BG,     1, RED,    1);
    px("p2_br",        149, 249, 0, 0, 12'h123,1, RED,    1);
    px("p2_right_out", 150, 200, 0, 0, 12'h456,1, 12'h456,0);
    px("p2_below_out", 100, 250, 0, 0, 12'h789,1, 12'h789,0);
    px("p2_left_out",   99, 200, 0, 0, BG,     1, BG,     0);

    // 3: mid-frame change has no effect until the next vblnk rise
    xpos_in = 12'd300;
    idle(8);
    px("p3_old_kept",  100, 200, 0, 0, BG, 1, RED, 1);
    px("p3_new_not",   300, 200, 0, 0, BG, 1, BG,  0);
    vpulse();
    px("p3_new_drawn", 300, 200, 0, 0, BG, 1, RED, 1);
    px("p3_old_gone",  100, 200, 0, 0, BG, 1, BG,  0);

    // 4: toggling bus never settles, so stable (300) persists through a frame edge
    for (int i = 0; i < 12; i++) begin
      xpos_in = (i % 2) ? 12'd7 : 12'd5;
      if (i == 8) px("vb_tog", 0, 500, 1, 1, 12'h000, 0, 12'h000, 0);
      else        idle(1);
    end
    xpos_in = 12'd5;
    px("p4_keep300", 300, 200, 0, 0, BG, 1, RED, 1);
    px("p4_no5",       5, 200, 0, 0, BG, 1, BG,  0);
    px("p4_no7",       7, 200, 0, 0, BG, 1, BG,  0);
    xpos_in = 12'd400;
    idle(6);
    vpulse();
    px("p4_settled",  400, 200, 0, 0, BG, 1, RED, 1);

    // 5: far-right position must not wrap; x=780 clips at the line end
    xpos_in = 12'd4090;
    idle(6);
    vpulse();
    px("p5_nowrap0",   0, 200, 0, 0, BG, 1, BG, 0);
    px("p5_nowrap10", 10, 200, 0, 0, BG, 1, BG, 0);
    px("p5_nowrap49", 49, 200, 0, 0, BG, 1, BG, 0);
    xpos_in = 12'd780;
    idle(6);
    vpulse();
    px("p5_clip780", 780, 200, 0, 0, BG, 1, RED, 1);
    px("p5_clip799", 799, 200, 0, 0, BG, 1, RED, 1);
    px("p5_clip779", 779, 200, 0, 0, BG, 1, BG,  0);

    // 6: reset mid-line flushes the pipe and restores the INIT shadow
    px("pre_rst_a", 790, 200, 0, 0, BG, 0, BG, 0);
    px("pre_rst_b", 791, 200, 0, 0, BG, 0, BG, 0);
    rst_px("rst_midline", 792, 200);
    @(posedge clk); #1; rst = 1'b0;
    px("p6_init_hit",  600, 1,   0, 0, BG, 1, RED, 1);
    px("p6_old_gone",  790, 200, 0, 0, BG, 1, BG,  0);

    idle(4);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        repeat (5000) @(posedge clk);
        errors++;
        $display("FAIL timeout: stimulus did not complete, got cycle %0d, want under 5000", cyc);
      end
    join_any
    disable fork;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
